// File: rtl/fp_cvt_seq_pkg.sv
// Shared FPU conversion definitions: op encodings, flag positions,
// integer/exponent constants and the converter FSM state type.
package fp_cvt_seq_pkg;

    // Operation encodings on in_op
    localparam logic [1:0] CVT_S_W  = 2'b00;  // signed int   -> float
    localparam logic [1:0] CVT_S_WU = 2'b01;  // unsigned int -> float
    localparam logic [1:0] CVT_W_S  = 2'b10;  // float -> signed int
    localparam logic [1:0] CVT_WU_S = 2'b11;  // float -> unsigned int

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] FLAGS_NONE = 5'b00000;
    localparam logic [4:0] FLAGS_NV   = 5'(1 << FLAG_NV);
    localparam logic [4:0] FLAGS_NX   = 5'(1 << FLAG_NX);

    // Exponent of 1.0, and exponent at which a value reaches 2^31
    localparam logic [7:0] EXP_BIAS    = 8'd127;
    localparam logic [7:0] EXP_INT_TOP = 8'd158;
    localparam logic [7:0] EXP_SPECIAL = 8'd255;

    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

    // -2^31 as a float: the one value at EXP_INT_TOP that fits a signed int
    localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_I2F_NORM  = 2'd1,
        ST_F2I_SHIFT = 2'd2,
        ST_DONE      = 2'd3
    } cvt_state_e;

endpackage

// File: rtl/fp_cvt_lzc8.sv
// Leading-zero count over a STEP-bit window (STEP <= 8), capped at STEP.
// Used by the normaliser to decide how far mag may move this cycle.
module fp_cvt_lzc8 #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] top_bits,
    output logic [3:0]      count
);

    // zero_prefix[i] is set when the top i+1 bits of the window are all zero
    logic [STEP-1:0] zero_prefix;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_prefix
        if (gi == 0) begin : g_first
            assign zero_prefix[gi] = ~top_bits[STEP-1];
        end else begin : g_rest
            assign zero_prefix[gi] = zero_prefix[gi-1] & ~top_bits[STEP-1-gi];
        end
    end

    // Count of set prefix bits equals the number of leading zeros (capped)
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < STEP; i++) begin
            count = count + {3'b000, zero_prefix[i]};
        end
    end

endmodule

// File: rtl/fp_cvt_seq.sv
// Multi-cycle FP32 <-> INT32 converter with round-toward-zero.
// Int->float normalises with an iterative left shift; float->int
// denormalises with an iterative right shift collecting a sticky bit.
module fp_cvt_seq
    import fp_cvt_seq_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_flags
);

    localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

    cvt_state_e  state_reg;
    logic [1:0]  op_reg;
    logic        sign_reg;
    logic [7:0]  exp_reg;
    logic [31:0] work_reg;     // int->float: magnitude; float->int: accumulator
    logic [4:0]  cnt_reg;
    logic        sticky_reg;
    logic [31:0] out_data_reg;
    logic [4:0]  out_flags_reg;
    logic        out_valid_reg;
    logic        in_ready_reg;

    logic        accept;
    logic [3:0]  norm_k;
    logic [4:0]  step_k;
    logic [31:0] lost_mask;
    logic        lost_bits;

    logic [31:0] i2f_mag;
    logic        i2f_sign;

    logic [7:0]  f2i_exp;
    logic        f2i_sign;
    logic        f2i_direct;
    logic [31:0] f2i_result;
    logic [4:0]  f2i_flags;
    logic [4:0]  f2i_cnt;

    assign accept    = in_valid && in_ready_reg;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_flags = out_flags_reg;

    // How far mag can move left this cycle without passing its leading one
    fp_cvt_lzc8 #(
        .STEP(SHIFT_STEP)
    ) u_lzc (
        .top_bits(work_reg[31 -: SHIFT_STEP]),
        .count   (norm_k)
    );

    // Right-shift amount this cycle and the bits it will discard
    always_comb begin
        step_k    = (cnt_reg < STEP_W) ? cnt_reg : STEP_W;
        lost_mask = (32'd1 << step_k) - 32'd1;
        lost_bits = |(work_reg & lost_mask);
    end

    // Int->float operand preparation: magnitude and sign
    always_comb begin
        i2f_sign = (in_op == CVT_S_W) && in_data[31];
        i2f_mag  = i2f_sign ? (~in_data + 32'd1) : in_data;
    end

    // Float->int classification: results that need no shifting are final here
    always_comb begin
        f2i_exp    = in_data[30:23];
        f2i_sign   = in_data[31];
        f2i_direct = 1'b1;
        f2i_result = 32'd0;
        f2i_flags  = FLAGS_NONE;
        f2i_cnt    = 5'(EXP_INT_TOP - f2i_exp);
        if (f2i_exp == EXP_SPECIAL) begin
            // NaN behaves like +Inf
            if ((in_data[22:0] != 23'd0) || !f2i_sign) begin
                f2i_result = (in_op == CVT_WU_S) ? UINT_MAX : INT_MAX;
            end else begin
                f2i_result = (in_op == CVT_WU_S) ? 32'd0 : INT_MIN;
            end
            f2i_flags = FLAGS_NV;
        end else if (f2i_exp < EXP_BIAS) begin
            // |x| < 1 truncates to zero; only inexact if nonzero
            f2i_flags = (in_data[30:0] != 31'd0) ? FLAGS_NX : FLAGS_NONE;
        end else if (in_op == CVT_WU_S) begin
            if (f2i_sign) begin
                f2i_flags = FLAGS_NV;
            end else if (f2i_exp > EXP_INT_TOP) begin
                f2i_result = UINT_MAX;
                f2i_flags  = FLAGS_NV;
            end else begin
                f2i_direct = 1'b0;
            end
        end else begin
            if (f2i_exp >= EXP_INT_TOP) begin
                if (in_data == FP_INT_MIN) begin
                    f2i_result = INT_MIN;
                end else begin
                    f2i_result = f2i_sign ? INT_MIN : INT_MAX;
                    f2i_flags  = FLAGS_NV;
                end
            end else begin
                f2i_direct = 1'b0;
            end
        end
    end

    // Converter FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= 2'd0;
            sign_reg      <= 1'b0;
            exp_reg       <= 8'd0;
            work_reg      <= 32'd0;
            cnt_reg       <= 5'd0;
            sticky_reg    <= 1'b0;
            out_data_reg  <= 32'd0;
            out_flags_reg <= 5'd0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        op_reg       <= in_op;
                        sticky_reg   <= 1'b0;
                        if (!in_op[1]) begin
                            if (in_data == 32'd0) begin
                                out_data_reg  <= 32'd0;
                                out_flags_reg <= FLAGS_NONE;
                                out_valid_reg <= 1'b1;
                                state_reg     <= ST_DONE;
                            end else begin
                                work_reg  <= i2f_mag;
                                sign_reg  <= i2f_sign;
                                exp_reg   <= EXP_INT_TOP;
                                state_reg <= ST_I2F_NORM;
                            end
                        end else begin
                            if (f2i_direct) begin
                                out_data_reg  <= f2i_result;
                                out_flags_reg <= f2i_flags;
                                out_valid_reg <= 1'b1;
                                state_reg     <= ST_DONE;
                            end else begin
                                work_reg  <= {1'b1, in_data[22:0], 8'd0};
                                sign_reg  <= f2i_sign;
                                cnt_reg   <= f2i_cnt;
                                state_reg <= ST_F2I_SHIFT;
                            end
                        end
                    end
                end

                ST_I2F_NORM: begin
                    if (!work_reg[31]) begin
                        work_reg <= work_reg << norm_k;
                        exp_reg  <= exp_reg - {4'd0, norm_k};
                    end else begin
                        out_data_reg  <= {sign_reg, exp_reg, work_reg[30:8]};
                        out_flags_reg <= (|work_reg[7:0]) ? FLAGS_NX : FLAGS_NONE;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end

                ST_F2I_SHIFT: begin
                    if (cnt_reg != 5'd0) begin
                        work_reg   <= work_reg >> step_k;
                        sticky_reg <= sticky_reg | lost_bits;
                        cnt_reg    <= cnt_reg - step_k;
                    end else begin
                        out_data_reg  <= ((op_reg == CVT_W_S) && sign_reg)
                                         ? (~work_reg + 32'd1) : work_reg;
                        out_flags_reg <= sticky_reg ? FLAGS_NX : FLAGS_NONE;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Directed bench for fp_cvt_seq: three instances (SHIFT_STEP 1, 4, 8) share
// the input side and are checked against hand-computed results and latencies.
module tb_fp_cvt_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_data = 32'd0;

    logic [2:0]        in_ready_w;
    logic [2:0]        out_valid_w;
    logic [2:0][31:0]  od;
    logic [2:0][4:0]   of;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_cvt_seq #(.SHIFT_STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_flags(of[0])
    );
    fp_cvt_seq #(.SHIFT_STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_flags(of[1])
    );
    fp_cvt_seq #(.SHIFT_STEP(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_flags(of[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Issue one operation to all three DUTs, wait for every result, check
    // data/flags (and latency when lz >= -1; lz == -1 means a 1-edge result).
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] exp_d, input logic [4:0] exp_f, input int lz);
        int lat [3];
        int cyc;
        int step;
        int exp_lat;
        lat = '{0, 0, 0};
        @(negedge clk);
        in_op    = op;
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;   // post-accept changes must not matter
        in_op    = ~op;
        cyc = 1;
        for (int k = 0; k < 3; k++) if (out_valid_w[k] && lat[k] == 0) lat[k] = cyc;
        while (out_valid_w != 3'b111 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 3; k++) if (out_valid_w[k] && lat[k] == 0) lat[k] = cyc;
        end
        check({name, " valid"}, {29'd0, out_valid_w}, 32'h7);
        for (int k = 0; k < 3; k++) begin
            step = (k == 0) ? 1 : ((k == 1) ? 4 : 8);
            check($sformatf("%s data s%0d", name, step), od[k], exp_d);
            check($sformatf("%s flags s%0d", name, step), {27'd0, of[k]}, {27'd0, exp_f});
            if (lz >= -1) begin
                exp_lat = (lz == -1) ? 1 : ((lz + step - 1) / step + 2);
                check($sformatf("%s lat s%0d", name, step), lat[k], exp_lat);
            end
        end
        $display("op=%0d in=%08h -> out=%08h flags=%05b lat=%0d/%0d/%0d (%s)",
                 op, data, od[0], of[0], lat[0], lat[1], lat[2], name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " ready after"}, {29'd0, in_ready_w}, 32'h7);
        check({name, " valid after"}, {29'd0, out_valid_w}, 32'h0);
    endtask

    initial begin
        int cyc;
        int highs;

        // Reset state
        #12;
        check("rst in_ready", {29'd0, in_ready_w}, 32'h7);
        check("rst out_valid", {29'd0, out_valid_w}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst data %0d", k), od[k], 32'h0);
            check($sformatf("rst flags %0d", k), {27'd0, of[k]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Int -> float
        run_op("sw_1",     2'b00, 32'h0000_0001, 32'h3F80_0000, 5'b00000, 31);
        run_op("sw_m1",    2'b00, 32'hFFFF_FFFF, 32'hBF80_0000, 5'b00000, 31);
        run_op("sw_max",   2'b00, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 5'b00001, 1);
        run_op("sw_min",   2'b00, 32'h8000_0000, 32'hCF00_0000, 5'b00000, 0);
        run_op("swu_top",  2'b01, 32'h8000_0000, 32'h4F00_0000, 5'b00000, 0);
        run_op("sw_zero",  2'b00, 32'h0000_0000, 32'h0000_0000, 5'b00000, -1);
        run_op("swu_1234", 2'b01, 32'h0000_1234, 32'h4591_A000, 5'b00000, 19);
        run_op("sw_m5",    2'b00, 32'hFFFF_FFFB, 32'hC0A0_0000, 5'b00000, 29);

        // Float -> int
        run_op("ws_pi",    2'b10, 32'h4049_0FDB, 32'h0000_0003, 5'b00001, -2);
        run_op("ws_mpi",   2'b10, 32'hC049_0FDB, 32'hFFFF_FFFD, 5'b00001, -2);
        run_op("ws_min",   2'b10, 32'hCF00_0000, 32'h8000_0000, 5'b00000, -2);
        run_op("ws_2p31",  2'b10, 32'h4F00_0000, 32'h7FFF_FFFF, 5'b10000, -2);
        run_op("ws_nan",   2'b10, 32'h7FC0_0000, 32'h7FFF_FFFF, 5'b10000, -2);
        run_op("ws_minf",  2'b10, 32'hFF80_0000, 32'h8000_0000, 5'b10000, -2);
        run_op("ws_one",   2'b10, 32'h3F80_0000, 32'h0000_0001, 5'b00000, -2);
        run_op("wus_m1",   2'b11, 32'hBF80_0000, 32'h0000_0000, 5'b10000, -2);
        run_op("wus_mhalf",2'b11, 32'hBF00_0000, 32'h0000_0000, 5'b00001, -2);
        run_op("wus_den",  2'b11, 32'h0000_0001, 32'h0000_0000, 5'b00001, -2);
        run_op("wus_2p31", 2'b11, 32'h4F00_0000, 32'h8000_0000, 5'b00000, -2);
        run_op("wus_2p32", 2'b11, 32'h4F80_0000, 32'hFFFF_FFFF, 5'b10000, -2);

        // Backpressure: result held while out_ready is low, new inputs ignored
        @(negedge clk);
        in_op = 2'b00; in_data = 32'h7FFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid_w != 3'b111 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp valid", {29'd0, out_valid_w}, 32'h7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c % 2 == 0);
            in_op    = 2'b10;
            in_data  = 32'h3F80_0000;
            @(posedge clk);
            #1;
            check($sformatf("bp hold data %0d", c), od[0], 32'h4EFF_FFFF);
            check($sformatf("bp hold flags %0d", c), {27'd0, of[2]}, 32'h1);
            check($sformatf("bp in_ready %0d", c), {29'd0, in_ready_w}, 32'h0);
            check($sformatf("bp out_valid %0d", c), {29'd0, out_valid_w}, 32'h7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release ready", {29'd0, in_ready_w}, 32'h7);
        check("bp release valid", {29'd0, out_valid_w}, 32'h0);
        highs = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_w != 3'b000) highs++;
        end
        check("bp no stale op", highs, 0);
        $display("backpressure case on in=7fffffff held 5 cycles");

        // Reset while holding a result in DONE clears the outputs at once
        @(negedge clk);
        in_op = 2'b00; in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid_w != 3'b111 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rd valid before", {29'd0, out_valid_w}, 32'h7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rd data", od[0] | od[1] | od[2], 32'h0);
        check("rd valid", {29'd0, out_valid_w}, 32'h0);
        check("rd ready", {29'd0, in_ready_w}, 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset during DONE on in=ffffffff");

        // Reset in the middle of normalisation aborts silently
        @(negedge clk);
        in_op = 2'b00; in_data = 32'h0000_0001; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) @(posedge clk);
        #2;
        check("rn busy", {29'd0, in_ready_w}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rn ready", {29'd0, in_ready_w}, 32'h7);
        check("rn valid", {29'd0, out_valid_w}, 32'h0);
        check("rn flags", {27'd0, of[0] | of[1] | of[2]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_w != 3'b000) highs++;
        end
        check("rn no stale valid", highs, 0);
        check("rn ready after", {29'd0, in_ready_w}, 32'h7);
        $display("reset during I2F_NORM on in=00000001");

        // Normal operation resumes after the abort
        run_op("post_rst", 2'b00, 32'h0000_0001, 32'h3F80_0000, 5'b00000, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_cvt_seq.md
Name: fp_cvt_seq

Overview:
Multi-cycle single-precision FP <-> 32-bit integer converter for the FPU (FCVT.S.W, FCVT.S.WU, FCVT.W.S, FCVT.WU.S). It is the decode/encode counterpart of the combinational add/sub datapath. Int->float runs the leading-zero normalise and pack step, and float->int unpacks and denormalises. Both iterate a shifter under an FSM, with valid/ready on both sides, sitting between the FP issue stage and FP writeback. Rounding is truncation (RTZ), matching the existing FP arithmetic units.

Parameters:
SHIFT_STEP, 1, max bit positions shifted per cycle in NORM/SHIFT states; legal values 1, 2, 4, 8.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand valid.
in_ready  out  1  high only in IDLE.
in_op  in  2  00 S.W (signed int->fp), 01 S.WU, 10 W.S (fp->signed int), 11 WU.S.
in_data  in  32  integer or IEEE-754 single operand.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts.
out_data  out  32  result.
out_flags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; in_ready=1; out_valid=0; out_data=0; out_flags=0; internal registers cleared.
  - Reset mid-operation aborts the conversion silently; no result is produced.
- States: IDLE, I2F_NORM, F2I_SHIFT, DONE. Accept when in_valid && in_ready; in_op and in_data are captured on that edge.
- Int->float on accept:
  - mag = |in_data| for op 00 (0x80000000 -> mag 0x80000000); in_data for op 01.
  - sign = in_data[31] for op 00, else 0. exp = 158.
  - mag==0: result 0x00000000, flags 0, go to DONE.
  - Otherwise go to I2F_NORM.
- I2F_NORM, each edge:
  - If mag[31]==0: shift mag left by k = min(SHIFT_STEP, leading zeros of mag); exp -= k.
  - Else: out_data={sign,exp,mag[30:8]}; NX=|mag[7:0]; go to DONE.
  - Latency from accept edge to out_valid: ceil(lz/SHIFT_STEP)+2 edges (SHIFT_STEP=1: lz+2).
- Float->int on accept: decode e=in_data[30:23], s=in_data[31].
  - NaN (e=255, frac!=0) or +Inf: op10 -> 0x7FFFFFFF, op11 -> 0xFFFFFFFF; NV=1; go to DONE.
  - -Inf: op10 -> 0x80000000, op11 -> 0; NV=1; go to DONE.
  - e<127 (includes zero and denormals): result 0; NX = (in_data[30:0]!=0); no NV, even for negative inputs with op11. Go to DONE.
  - op10 with e>=158: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1) with NV. Exception: exactly 0xCF000000 gives 0x80000000 with no flags.
  - op11 with e>=159: 0xFFFFFFFF, NV.
  - op11 with s=1 and e>=127: 0, NV.
  - Otherwise: acc={1,frac,8'b0}; cnt=158-e (0..31); go to F2I_SHIFT.
- F2I_SHIFT, each edge:
  - If cnt!=0: shift acc right by k=min(SHIFT_STEP,cnt); sticky |= shifted-out bits; cnt -= k.
  - When cnt==0: result = s ? -acc : acc (op10), acc (op11); NX=sticky; go to DONE.
- DONE:
  - out_valid=1; out_data and out_flags are held stable until out_ready.
  - On the edge where out_valid && out_ready, go to IDLE.
  - in_ready=0 throughout, so there is at most one operation in flight and no accept/complete overlap.
- in_valid while not in IDLE is ignored (no capture). in_op/in_data changes after accept have no effect.

Decomposition:
- Shared FPU package:
  - op encodings (CVT_S_W, CVT_S_WU, CVT_W_S, CVT_WU_S);
  - flag bit indices;
  - constants EXP_BIAS=127, EXP_INT_TOP=158, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000, UINT_MAX=0xFFFFFFFF;
  - FSM state typedef.
- One sub-module: fp_cvt_lzc8. It returns the leading-zero count of the top SHIFT_STEP bits, capped at SHIFT_STEP, and is used by I2F_NORM.

Test Plan:
- S.W in_data=0x00000001, SHIFT_STEP=1 -> out_data=0x3F800000, flags 0, out_valid 33 edges after accept; in_data=0xFFFFFFFF -> 0xBF800000.
- S.W 0x7FFFFFFF -> 0x4EFFFFFF, NX=1. S.W 0x80000000 -> 0xCF000000, flags 0. S.WU 0x80000000 -> 0x4F000000. S.W 0 -> 0x00000000, valid after 1 edge.
- W.S 0x40490FDB (3.14159) -> 3, NX=1. W.S 0xC0490FDB -> 0xFFFFFFFD, NX=1. W.S 0xCF000000 -> 0x80000000, flags 0. W.S 0x4F000000 -> 0x7FFFFFFF, NV=1.
- W.S 0x7FC00000 -> 0x7FFFFFFF, NV. WU.S 0xBF800000 -> 0, NV. WU.S 0xBF000000 (-0.5) -> 0, NX only. WU.S 0x00000001 (denormal) -> 0, NX.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Assert rst_n=0 mid I2F_NORM on operand 1 -> outputs immediately 0 and in_ready=1; after release no stale out_valid. Repeat all int->float cases with SHIFT_STEP=4 and 8 -> identical results, latency ceil(lz/STEP)+2.
